dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
// - Sequencer/arbiter in front of the byte-wide data memory (8-bit lanes, ADDR_W address bits).
// - Shares it between two requesters: port 0 (pipeline MEM stage) and port 1 (loader/debug).
// - Breaks each 32-bit word access into 4 little-endian byte cycles; a byte access is 1 cycle.
// - Replaces level-triggered read/write strobes with a clocked req/done handshake.
// PARAMETERS
// - N       32  requester data/address width
// - ADDR_W  12  memory byte-address width; upper requester address bits are ignored
// - DATA_W   8  memory lane width; N must equal 4*DATA_W
// PORTS
// - clk       in   1       single clock, rising edge
// - rst       in   1       synchronous, active-high reset
// - pX_req    in   1       X in {0,1}: request, sampled only in IDLE
// - pX_we     in   1       1 = write, 0 = read
// - pX_byte   in   1       1 = byte access, 0 = word access
// - pX_addr   in   N       byte address; [ADDR_W-1:0] used
// - pX_wdata  in   N       write data; [DATA_W-1:0] for byte writes
// - pX_rdata  out  N       read data, registered, held until that port's next read done
// - pX_done   out  1       1-cycle completion pulse
// - mem_addr  out  ADDR_W  memory byte address
// - mem_wdata out  DATA_W  memory write byte
// - mem_we    out  1       memory write strobe; memory writes on the clk edge
// - mem_re    out  1       memory read strobe; mem_rdata is valid the following cycle
// - mem_rdata in   DATA_W  memory read byte
// - busy      out  1       high in every state except IDLE
// BEHAVIOUR
// - Reset: state IDLE.
//   - All outputs 0: pX_done, pX_rdata, mem_*, busy.
//   - last_grant = 1, so port 0 wins the first tie.
// - FSM states: IDLE, XFER, WAIT, DONE.
// - IDLE:
//   - No requests: stay in IDLE.
//   - One request: grant it.
//   - Both request: grant the port that is not last_grant (round-robin), then update last_grant.
//   - On grant: latch we/byte/addr/wdata, set cnt = 0, go to XFER.
// - XFER: one memory strobe per cycle.
//   - mem_addr = (addr + cnt) mod 2^ADDR_W; wraps, no error.
//   - mem_wdata = wdata[8*cnt +: 8].
//   - cnt runs 0..3 for word access, 0 for byte access.
//   - At the last byte: a read goes to WAIT; a write goes to DONE.
// - Read capture: the byte strobed in cycle c is stored into lane cnt of a shadow register at the end of cycle c+1.
//   - WAIT exists to capture the final byte.
//   - No mem strobe is driven in WAIT.
// - DONE:
//   - Assert the granted port's done for exactly 1 cycle.
//   - On a read, copy the shadow register to pX_rdata in the same edge that raises done.
//   - Byte reads are zero-extended to N bits.
//   - Return to IDLE.
// - Latency in cycles, counted from the req-sampling edge to the done cycle:
//   - word read 6, byte read 3, word write 5, byte write 2.
// - Requester obligations:
//   - Hold req and its signals stable until done.
//   - Drop req in the cycle done is high; a req still high in IDLE is treated as a new transaction.
//   - Deasserting req mid-transaction has no effect; the transaction completes.
// - Non-granted port: its req is ignored until IDLE; it sees no done pulse and its rdata is unchanged.
// - The non-granted port's pX_rdata is never modified.
// - mem_we and mem_re are never high together; both are 0 outside XFER.
// - Reset mid-operation:
//   - Abort at the next edge and return to IDLE with reset values.
//   - Bytes already written stay in memory; there is no rollback.
// STRUCTURE
// - Shared package dmem_pkg: state enum (IDLE/XFER/WAIT/DONE), LANES = 4, lane index width 2.
// - Sub-module rr_arbiter2: 2-request round-robin arbiter with last_grant register.
//   - Inputs: req[1:0], an advance enable, rst.
//   - Output: one-hot grant.
// - Everything else lives in this module: FSM, byte counter, shadow register, mem mux.
// TESTING
// - Word write/read, port 0:
//   - Write 0xDEADBEEF to addr 0x010, then read it back.
//   - Memory bytes 0x010..0x013 = EF,BE,AD,DE.
//   - p0_rdata = 0xDEADBEEF; p0_done exactly 6 cycles after the read req is sampled.
// - Byte access, port 1:
//   - Byte write 0x1234_56A5 to addr 0x7FF; only byte 0xA5 is stored.
//   - Byte read of 0x7FF returns p1_rdata = 0x000000A5 in 3 cycles.
// - Wrap-around:
//   - Word write 0x11223344 at addr 0xFFE.
//   - Bytes land at 0xFFE,0xFFF,0x000,0x001 = 44,33,22,11.
// - Contention:
//   - p0 and p1 both hold req from reset.
//   - Grant order is p0, p1, p0, p1.
//   - Each port sees one done per transaction; the other port's rdata is unchanged.
// - Reset mid-word-write:
//   - Assert rst during the 3rd XFER cycle.
//   - Next cycle: busy = 0, mem_we = 0.
//   - Bytes 0 and 1 are written, bytes 2 and 3 are untouched; no done pulse.
// - Protocol check:
//   - Assertions that mem_we and mem_re are never both high, and that done is a 1-cycle pulse.
//   - Run with randomized reqs for 10k cycles against a byte-array scoreboard.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WAIT,
    DONE
  } state_t;

  // Index of the final byte cycle: lane 0 for a byte access, lane 3 for a word.
  function automatic logic [LANE_W-1:0] last_lane(input logic is_byte);
    return is_byte ? '0 : LANE_W'(LANES - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the port that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  // Pick a one-hot winner from the current requests and the previous winner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner only when the grant is actually taken; reset favours port 0
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates two requesters onto a byte-wide
// memory and sequences each word access as four little-endian byte cycles.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_byte,
  input  logic [N-1:0]      p0_addr,
  input  logic [N-1:0]      p0_wdata,
  output logic [N-1:0]      p0_rdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_byte,
  input  logic [N-1:0]      p1_addr,
  input  logic [N-1:0]      p1_wdata,
  output logic [N-1:0]      p1_rdata,
  output logic              p1_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t                       state;
  logic [1:0]                   grant;
  logic                         sel_we;
  logic                         sel_byte;
  logic [ADDR_W-1:0]            sel_addr;
  logic [LANES-1:0][DATA_W-1:0] sel_wdata;
  logic                         port_q;
  logic                         we_q;
  logic                         byte_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [LANES-1:0][DATA_W-1:0] wdata_q;
  logic [LANE_W-1:0]            cnt;
  logic [LANE_W-1:0]            cnt_next;
  logic                         we_strobe;
  logic                         re_strobe;
  logic                         cap_valid;
  logic [LANE_W-1:0]            cap_lane;
  logic [LANES-1:0][DATA_W-1:0] shadow;
  logic [LANES-1:0][DATA_W-1:0] shadow_next;
  logic [N-1:0]                 read_result;
  logic                         unused_addr_bits;

  assign unused_addr_bits = ^{p0_addr[N-1:ADDR_W], p1_addr[N-1:ADDR_W]};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({p1_req, p0_req}),
    .advance (state == IDLE),
    .grant   (grant)
  );

  // Steer the winning requester's command fields toward the transaction latches
  always_comb begin
    sel_we    = grant[1] ? p1_we    : p0_we;
    sel_byte  = grant[1] ? p1_byte  : p0_byte;
    sel_addr  = grant[1] ? p1_addr[ADDR_W-1:0] : p0_addr[ADDR_W-1:0];
    sel_wdata = grant[1] ? p1_wdata : p0_wdata;
  end

  assign cnt_next = cnt + 1'b1;

  // The byte strobed last cycle arrives now; merge it into its lane of the shadow word
  always_comb begin
    shadow_next = shadow;
    if (cap_valid) begin
      shadow_next[cap_lane] = mem_rdata;
    end
  end

  // Final read value, including the lane landing this cycle; byte reads are zero-extended
  always_comb begin
    read_result = shadow_next;
    if (byte_q) begin
      read_result = {{(N-DATA_W){1'b0}}, shadow_next[0]};
    end
  end

  // Strobes are masked by rst so the edge that applies a reset never commits a memory write
  assign mem_we = we_strobe & ~rst;
  assign mem_re = re_strobe & ~rst;

  // Transaction sequencer: grant, byte cycles, final read capture, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      we_strobe <= 1'b0;
      re_strobe <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cap_valid <= 1'b0;
      cap_lane  <= '0;
      shadow    <= '0;
      busy      <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      shadow    <= shadow_next;
      cap_valid <= re_strobe;
      cap_lane  <= cnt;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            port_q    <= grant[1];
            we_q      <= sel_we;
            byte_q    <= sel_byte;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            cnt       <= '0;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata[0];
            we_strobe <= sel_we;
            re_strobe <= ~sel_we;
            busy      <= 1'b1;
            state     <= XFER;
          end
        end
        XFER: begin
          if (cnt == last_lane(byte_q)) begin
            we_strobe <= 1'b0;
            re_strobe <= 1'b0;
            if (we_q) begin
              state <= DONE;
              if (port_q) p1_done <= 1'b1;
              else        p0_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            cnt       <= cnt_next;
            mem_addr  <= addr_q + ADDR_W'(cnt_next);
            mem_wdata <= wdata_q[cnt_next];
          end
        end
        WAIT: begin
          state <= DONE;
          if (port_q) begin
            p1_done  <= 1'b1;
            p1_rdata <= read_result;
          end else begin
            p0_done  <= 1'b1;
            p0_rdata <= read_result;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus a randomized
// two-port run, checked against a byte-array reference memory and an expectation queue.
module tb_dmem_access_ctrl;

  localparam int N      = 32;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    bit                port;
    bit                is_read;
    bit                is_byte;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      wdata;
    int                start;
    int                lat;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p0_we, p0_byte, p0_done;
  logic [N-1:0]      p0_addr, p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_byte, p1_done;
  logic [N-1:0]      p1_addr, p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re, busy;
  logic [DATA_W-1:0] mem_rdata = 8'h00;
  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: 8'h00};

  txn_t              sb_q[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [N-1:0]      exp_rd [2];
  bit                got_done [2];
  bit                prev_done [2];
  bit                pending [2];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;

  dmem_access_ctrl #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_byte   (p0_byte),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rdata  (p0_rdata),
    .p0_done   (p0_done),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_byte   (p1_byte),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_rdata  (p1_rdata),
    .p1_done   (p1_done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide data memory: writes on the edge, read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  function automatic int expLatency(input bit is_read, input bit is_byte);
    if (is_read) return is_byte ? 3 : 6;
    return is_byte ? 2 : 5;
  endfunction

  function automatic logic [N-1:0] modelRead(input logic [ADDR_W-1:0] a, input bit byt);
    logic [N-1:0]      v;
    logic [ADDR_W-1:0] ai;
    v = '0;
    for (int i = 0; i < (byt ? 1 : 4); i++) begin
      ai = a + ADDR_W'(i);
      v[8*i +: 8] = ref_mem[ai];
    end
    return v;
  endfunction

  task automatic modelWrite(input logic [ADDR_W-1:0] a, input bit byt, input logic [N-1:0] wd);
    logic [ADDR_W-1:0] ai;
    for (int i = 0; i < (byt ? 1 : 4); i++) begin
      ai = a + ADDR_W'(i);
      ref_mem[ai] = wd[8*i +: 8];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic driveReq(input int port, input bit we, input bit byt,
                          input logic [N-1:0] addr, input logic [N-1:0] wdata);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_byte = byt; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_byte = byt; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic dropReq(input int port);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  task automatic pushTxn(input int port, input bit we, input bit byt,
                         input logic [N-1:0] addr, input logic [N-1:0] wdata, input int start);
    txn_t t;
    t.port    = (port != 0);
    t.is_read = !we;
    t.is_byte = byt;
    t.addr    = addr[ADDR_W-1:0];
    t.wdata   = wdata;
    t.start   = start;
    t.lat     = expLatency(!we, byt);
    sb_q.push_back(t);
  endtask

  // One clock: sample away from the active edge, run protocol checks, retire completions
  task automatic tick();
    logic [1:0]   dn;
    logic [N-1:0] rd [2];
    int           idx;
    txn_t         t;
    @(negedge clk);
    dn = {p1_done, p0_done};
    rd[0] = p0_rdata;
    rd[1] = p1_rdata;
    got_done[0] = 1'b0;
    got_done[1] = 1'b0;
    if (mem_we || mem_re) checkOutput("strobe_exclusive", N'(mem_we & mem_re), N'(0));
    if (dn != 2'b00) checkOutput("single_done", N'(dn[0] & dn[1]), N'(0));
    for (int p = 0; p < 2; p++) begin
      if (dn[p]) begin
        checkOutput($sformatf("done_pulse_p%0d", p), N'(prev_done[p]), N'(0));
        idx = -1;
        foreach (sb_q[i]) if (idx < 0 && sb_q[i].port == (p != 0)) idx = i;
        checkOutput($sformatf("done_expected_p%0d", p), N'(idx >= 0), N'(1));
        if (idx >= 0) begin
          t = sb_q[idx];
          sb_q.delete(idx);
          got_done[p] = 1'b1;
          if (t.start >= 0)
            checkOutput($sformatf("latency_p%0d", p), N'(cyc - t.start), N'(t.lat));
          if (t.is_read) exp_rd[p] = modelRead(t.addr, t.is_byte);
          else           modelWrite(t.addr, t.is_byte, t.wdata);
          checkOutput($sformatf("rdata_p%0d", p), rd[p], exp_rd[p]);
          checkOutput($sformatf("rdata_other_p%0d", 1 - p), rd[1-p], exp_rd[1-p]);
        end
      end
      prev_done[p] = dn[p];
    end
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 50; k++) begin
      if (busy === 1'b0) break;
      tick();
    end
    checkOutput("idle_reached", N'(busy), N'(0));
  endtask

  // Issue one transaction on an idle controller and wait for its completion
  task automatic applyStimulus(input int port, input bit we, input bit byt,
                               input logic [N-1:0] addr, input logic [N-1:0] wdata);
    waitIdle();
    driveReq(port, we, byt, addr, wdata);
    pushTxn(port, we, byt, addr, wdata, cyc);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) checkOutput("busy_during_xfer", N'(busy), N'(1));
      if (got_done[port]) break;
    end
    checkOutput($sformatf("done_seen_p%0d", port), N'(got_done[port]), N'(1));
    dropReq(port);
  endtask

  initial begin
    int               c0;
    bit               we, byt;
    logic [19:0]      hi;
    logic [ADDR_W-1:0] lo;
    logic [N-1:0]     wd;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_byte = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_byte = 1'b0; p1_addr = '0; p1_wdata = '0;
    tick();
    tick();

    checkOutput("rst_busy",      N'(busy),      N'(0));
    checkOutput("rst_mem_we",    N'(mem_we),    N'(0));
    checkOutput("rst_mem_re",    N'(mem_re),    N'(0));
    checkOutput("rst_mem_addr",  N'(mem_addr),  N'(0));
    checkOutput("rst_mem_wdata", N'(mem_wdata), N'(0));
    checkOutput("rst_p0_done",   N'(p0_done),   N'(0));
    checkOutput("rst_p1_done",   N'(p1_done),   N'(0));
    checkOutput("rst_p0_rdata",  p0_rdata,      N'(0));
    checkOutput("rst_p1_rdata",  p1_rdata,      N'(0));
    rst = 1'b0;
    tick();

    $display("[TB] word write/read on port 0");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    checkOutput("mem_010", N'(mem[12'h010]), N'(8'hEF));
    checkOutput("mem_011", N'(mem[12'h011]), N'(8'hBE));
    checkOutput("mem_012", N'(mem[12'h012]), N'(8'hAD));
    checkOutput("mem_013", N'(mem[12'h013]), N'(8'hDE));
    applyStimulus(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    checkOutput("p0_word_read", p0_rdata, 32'hDEAD_BEEF);

    $display("[TB] byte access on port 1");
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_07FF, 32'h1234_56A5);
    checkOutput("mem_7ff", N'(mem[12'h7FF]), N'(8'hA5));
    checkOutput("mem_800", N'(mem[12'h800]), N'(8'h00));
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_07FF, 32'h0);
    checkOutput("p1_byte_read", p1_rdata, 32'h0000_00A5);

    $display("[TB] address wrap-around");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0FFE, 32'h1122_3344);
    checkOutput("mem_ffe", N'(mem[12'hFFE]), N'(8'h44));
    checkOutput("mem_fff", N'(mem[12'hFFF]), N'(8'h33));
    checkOutput("mem_000", N'(mem[12'h000]), N'(8'h22));
    checkOutput("mem_001", N'(mem[12'h001]), N'(8'h11));
    applyStimulus(0, 1'b0, 1'b0, 32'h0000_0FFE, 32'h0);

    $display("[TB] reset during word write");
    waitIdle();
    driveReq(1, 1'b1, 1'b0, 32'h0000_0100, 32'hCAFE_F00D);
    tick();
    tick();
    tick();
    checkOutput("xfer3_we",   N'(mem_we),   N'(1));
    checkOutput("xfer3_addr", N'(mem_addr), N'(12'h102));
    rst = 1'b1;
    dropReq(1);
    tick();
    checkOutput("abort_busy",     N'(busy),   N'(0));
    checkOutput("abort_mem_we",   N'(mem_we), N'(0));
    checkOutput("abort_p0_rdata", p0_rdata,   N'(0));
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checkOutput("abort_mem_100", N'(mem[12'h100]), N'(8'h0D));
    checkOutput("abort_mem_101", N'(mem[12'h101]), N'(8'hF0));
    checkOutput("abort_mem_102", N'(mem[12'h102]), N'(8'h00));
    checkOutput("abort_mem_103", N'(mem[12'h103]), N'(8'h00));
    ref_mem[12'h100] = 8'h0D;
    ref_mem[12'h101] = 8'hF0;

    $display("[TB] contention from reset");
    rst = 1'b1;
    driveReq(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0BAD_C0DE);
    driveReq(1, 1'b0, 1'b0, 32'h0000_0200, 32'h0);
    tick();
    tick();
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b0;
    c0 = cyc;
    pushTxn(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0BAD_C0DE, c0);
    pushTxn(1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,         c0 + 6);
    pushTxn(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0BAD_C0DE, c0 + 13);
    pushTxn(1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,         c0 + 19);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (sb_q.size() == 0) break;
    end
    dropReq(0);
    dropReq(1);
    checkOutput("contention_drained", N'(sb_q.size()), N'(0));
    checkOutput("contention_p1_rdata", p1_rdata, 32'h0BAD_C0DE);
    checkOutput("contention_p0_rdata", p0_rdata, N'(0));

    $display("[TB] randomized two-port traffic");
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (got_done[p]) begin
          dropReq(p);
          pending[p] = 1'b0;
        end else if (!pending[p] && $urandom_range(0, 3) == 0) begin
          we  = 1'($urandom_range(0, 1));
          byt = 1'($urandom_range(0, 1));
          hi  = 20'($urandom());
          lo  = 12'hFF8 + 12'($urandom_range(0, 15));
          wd  = $urandom();
          driveReq(p, we, byt, {hi, lo}, wd);
          pushTxn(p, we, byt, {hi, lo}, wd, -1);
          pending[p] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (sb_q.size() == 0) break;
      tick();
      for (int p = 0; p < 2; p++) if (got_done[p]) dropReq(p);
    end
    dropReq(0);
    dropReq(1);
    checkOutput("random_drained", N'(sb_q.size()), N'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
